// File: rtl/move_validator.sv
// ---------------------------------------------------------------------------
// move_validator
//   Checks one chess move requested by the control block. It reads the source
//   and destination squares from board memory, applies the piece geometry
//   rules, walks any squares strictly between source and destination for
//   sliding moves, and returns a verdict.
//
// Handshake (level based):
//   start is the request. control raises it once board memory has been
//   granted and holds it until it sees validate_complete. validate_complete
//   is high for as long as the FSM sits in DONE, and move_valid is meaningful
//   only while validate_complete is high. Dropping start releases memory and
//   returns the FSM to IDLE on the next edge. If start drops before DONE, the
//   request is aborted: no validate_complete is produced and move_valid is
//   cleared.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               level request from control
//   current_player      0 = pieces 1-6, 1 = pieces 7-12
//   piece_x, piece_y    source square, (0,0) is the bottom-left corner
//   move_x, move_y      destination square
//   piece_to_move       piece code latched by control at selection
//   mem_addr            board address {y,x}
//   mem_rd_en           high whenever mem_addr is meaningful
//   mem_rdata           board contents, valid one cycle after mem_addr
//   busy                high in every state except IDLE
//   validate_complete   high while in DONE
//   move_valid          verdict
//   state_dbg           current FSM state encoding
// ---------------------------------------------------------------------------
module move_validator #(
    parameter logic [2:0] P0_PAWN_ROW = 3'd1,
    parameter logic [2:0] P1_PAWN_ROW = 3'd6,
    parameter bit         CHECK_OWNER = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       current_player,
    input  logic [2:0] piece_x,
    input  logic [2:0] piece_y,
    input  logic [2:0] move_x,
    input  logic [2:0] move_y,
    input  logic [3:0] piece_to_move,
    output logic [5:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [3:0] mem_rdata,
    output logic       busy,
    output logic       validate_complete,
    output logic       move_valid,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_SRC   = 3'd1,
        RD_DST   = 3'd2,
        CLASSIFY = 3'd3,
        WALK_A   = 3'd4,
        WALK_D   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t     state, state_next;
    logic [3:0] src_code;
    logic [2:0] cur_x, cur_y;
    logic [2:0] step_x, step_y;

    // ------------------------------------------------------------------
    // Move classification. The destination contents are taken straight
    // from mem_rdata while in CLASSIFY, which is the cycle they are valid.
    // ------------------------------------------------------------------
    logic [3:0] dx, dy, adx, ady;
    logic [2:0] step_x_c, step_y_c;
    logic [3:0] dst_code;
    logic [3:0] ptype;
    logic [3:0] fwd, fwd2;
    logic [2:0] pawn_row;
    logic       src_owner, src_legal, owner_ok;
    logic       dst_empty, dst_opp;
    logic       basic_ok, geo_ok, need_walk, long_path;
    logic       pawn_single, pawn_double, pawn_capture;
    logic       rook_geo, bishop_geo, knight_geo, king_geo;
    logic [2:0] next_x, next_y;
    logic       walk_last;

    always_comb begin
        // 4-bit two's complement differences; range -7..+7
        dx = {1'b0, move_x} - {1'b0, piece_x};
        dy = {1'b0, move_y} - {1'b0, piece_y};
        adx = dx[3] ? (4'd0 - dx) : dx;
        ady = dy[3] ? (4'd0 - dy) : dy;
        // Steps are 3-bit addends: 3'b111 adds -1 modulo 8
        step_x_c = (dx == 4'd0) ? 3'd0 : (dx[3] ? 3'b111 : 3'd1);
        step_y_c = (dy == 4'd0) ? 3'd0 : (dy[3] ? 3'b111 : 3'd1);

        dst_code  = mem_rdata;
        src_owner = (src_code >= 4'd7);
        src_legal = (src_code != 4'd0) && (src_code <= 4'd12);
        owner_ok  = !CHECK_OWNER || (src_owner == current_player);
        dst_empty = (dst_code == 4'd0);
        // Opponent relative to the owner of the moving piece
        dst_opp   = (dst_code != 4'd0) && (dst_code <= 4'd12) &&
                    ((dst_code >= 4'd7) != src_owner);

        basic_ok = ((dx != 4'd0) || (dy != 4'd0)) &&
                   (src_code == piece_to_move) && src_legal && owner_ok &&
                   (dst_empty || dst_opp);

        ptype    = src_owner ? (src_code - 4'd6) : src_code;
        fwd      = src_owner ? 4'b1111 : 4'd1;
        fwd2     = src_owner ? 4'b1110 : 4'd2;
        pawn_row = src_owner ? P1_PAWN_ROW : P0_PAWN_ROW;

        pawn_single  = (dx == 4'd0) && (dy == fwd) && dst_empty;
        pawn_double  = (dx == 4'd0) && (dy == fwd2) && (piece_y == pawn_row) && dst_empty;
        pawn_capture = (adx == 4'd1) && (dy == fwd) && dst_opp;
        rook_geo     = (dx == 4'd0) || (dy == 4'd0);
        bishop_geo   = (adx == ady);
        knight_geo   = ((adx == 4'd1) && (ady == 4'd2)) || ((adx == 4'd2) && (ady == 4'd1));
        king_geo     = (adx <= 4'd1) && (ady <= 4'd1);

        geo_ok = 1'b0;
        case (ptype)
            4'd1:    geo_ok = pawn_single || pawn_double || pawn_capture;
            4'd2:    geo_ok = rook_geo;
            4'd3:    geo_ok = knight_geo;
            4'd4:    geo_ok = bishop_geo;
            4'd5:    geo_ok = rook_geo || bishop_geo;
            4'd6:    geo_ok = king_geo;
            default: geo_ok = 1'b0;
        endcase

        // Only moves spanning more than one square have intermediates.
        // Knight and king jump by definition; legal pawn single steps and
        // captures never span more than one square.
        long_path = (adx > 4'd1) || (ady > 4'd1);
        need_walk = geo_ok && long_path && (ptype != 4'd3) && (ptype != 4'd6);

        next_x    = cur_x + step_x;
        next_y    = cur_y + step_y;
        walk_last = (next_x == move_x) && (next_y == move_y);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Dropping start outside IDLE/DONE aborts.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (start) state_next = RD_SRC;
            RD_SRC:   state_next = start ? RD_DST : IDLE;
            RD_DST:   state_next = start ? CLASSIFY : IDLE;
            CLASSIFY: begin
                if (!start) begin
                    state_next = IDLE;
                end else if (basic_ok && need_walk) begin
                    state_next = WALK_A;
                end else begin
                    state_next = DONE;
                end
            end
            WALK_A:   state_next = start ? WALK_D : IDLE;
            WALK_D: begin
                if (!start) begin
                    state_next = IDLE;
                end else if ((mem_rdata != 4'd0) || walk_last) begin
                    state_next = DONE;
                end else begin
                    state_next = WALK_A;
                end
            end
            DONE:     if (!start) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr          = 6'd0;
        mem_rd_en         = 1'b0;
        busy              = (state != IDLE);
        validate_complete = (state == DONE);
        unique case (state)
            RD_SRC: begin
                mem_addr  = {piece_y, piece_x};
                mem_rd_en = 1'b1;
            end
            RD_DST: begin
                mem_addr  = {move_y, move_x};
                mem_rd_en = 1'b1;
            end
            WALK_A: begin
                mem_addr  = {cur_y, cur_x};
                mem_rd_en = 1'b1;
            end
            default: begin
                mem_addr  = 6'd0;
                mem_rd_en = 1'b0;
            end
        endcase
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Datapath: source code, walk cursor and verdict
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            src_code   <= 4'd0;
            cur_x      <= 3'd0;
            cur_y      <= 3'd0;
            step_x     <= 3'd0;
            step_y     <= 3'd0;
            move_valid <= 1'b0;
        end else if (!start) begin
            // Covers both abort and normal release from DONE
            move_valid <= 1'b0;
        end else begin
            case (state)
                IDLE:   move_valid <= 1'b0;
                RD_DST: src_code   <= mem_rdata;
                CLASSIFY: begin
                    move_valid <= basic_ok && geo_ok && !need_walk;
                    cur_x      <= piece_x + step_x_c;
                    cur_y      <= piece_y + step_y_c;
                    step_x     <= step_x_c;
                    step_y     <= step_y_c;
                end
                WALK_D: begin
                    move_valid <= (mem_rdata == 4'd0) && walk_last;
                    cur_x      <= next_x;
                    cur_y      <= next_y;
                end
                default: ;
            endcase
        end
    end

endmodule
